// File: rtl/latency_ram.sv
`default_nettype none
// ============================================================================
// Module      : latency_ram
// Description : Word-addressed 32-bit main-memory model with a fixed access
//               latency. A request starts whenever the inputs change. Optional
//               macro RAM_WR_READBACK_EN also loads out with the write data.
// Revision    : 1.0 - initial release
// ============================================================================
module latency_ram #(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data,
    input  logic [31:0] addr,
    input  logic        wr,
    output logic        response,
    output logic [31:0] out
);

    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    logic [31:0]       data_q;
    logic [31:0]       addr_q;
    logic              wr_q;
    logic [7:0]        cnt;
    logic              done;
    logic [31:0]       mem [0:(1 << ADDR_W) - 1];

    logic              mismatch;
    logic              do_access;
    logic [ADDR_W-1:0] idx;

    assign mismatch  = (data != data_q) | (addr != addr_q) | (wr != wr_q);
    assign response  = done & ~mismatch;
    assign do_access = ~mismatch & ~done & (cnt == 8'd0);
    assign idx       = addr_q[ADDR_W-1:0];

    // A changed input always wins, so an in-flight request is silently dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= 32'd0;
            addr_q <= 32'd0;
            wr_q   <= 1'b0;
            cnt    <= 8'd0;
            done   <= 1'b1;
            out    <= 32'd0;
        end else if (mismatch) begin
            data_q <= data;
            addr_q <= addr;
            wr_q   <= wr;
            done   <= 1'b0;
            cnt    <= CNT_INIT;
        end else if (!done) begin
            if (cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end else begin
                done <= 1'b1;
                if (!wr_q) begin
                    out <= mem[idx];
                end
`ifdef RAM_WR_READBACK_EN
                else begin
                    out <= data_q;
                end
`endif
            end
        end
    end

    // Array write kept out of the reset block; reset held at an edge blocks it.
    always_ff @(posedge clk) begin
        if (do_access && wr_q && !rst) begin
            mem[idx] <= data_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_latency_ram.sv
`default_nettype none
// Scoreboard bench for latency_ram: stimulus pushes expected completions,
// a negedge monitor pops them on every rising response.
module tb_latency_ram;

    localparam int ADDR_W  = 12;
    localparam int LATENCY = 4;
    localparam logic [31:0] LOW_MASK = (32'd1 << ADDR_W) - 32'd1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] data = 32'd0;
    logic [31:0] addr = 32'd0;
    logic        wr = 1'b0;
    logic        response;
    logic [31:0] out;

    latency_ram #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst(rst), .data(data), .addr(addr), .wr(wr),
        .response(response), .out(out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] val;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic [31:0] mem_m [int];
    logic [31:0] cur_out = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        int k;
        k = int'(a & LOW_MASK);
        return mem_m.exists(k) ? mem_m[k] : 32'd0;
    endfunction

    // Reference: the request's effect on memory and out, completing 1+LATENCY
    // cycles after the cycle in which the inputs were changed.
    task automatic push_expected(input logic [31:0] d, input logic [31:0] a, input logic w);
        exp_t e;
        if (w) begin
            mem_m[int'(a & LOW_MASK)] = d;
`ifdef RAM_WR_READBACK_EN
            cur_out = d;
`endif
        end else begin
            cur_out = mem_rd(a);
        end
        e.val = cur_out;
        e.cyc = cyc + 1 + LATENCY;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < LATENCY + 4; i++) begin
            @(negedge clk); #1;
            if (response) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_timeout"}, {31'd0, seen}, 32'd1);
    endtask

    task automatic drive(input logic [31:0] d, input logic [31:0] a, input logic w);
        data = d;
        addr = a;
        wr   = w;
        #1;
        check("resp_drop", {31'd0, response}, 32'd0);
    endtask

    // abort_j > 0: replace the request after abort_j accepted-request edges.
    task automatic issue(input string name, input logic [31:0] d, input logic [31:0] a,
                         input logic w, input int abort_j);
        drive(d, a, w);
        if (abort_j > 0) begin
            repeat (abort_j) @(negedge clk);
            #1;
        end else begin
            push_expected(d, a, w);
            wait_done(name);
        end
    endtask

    // Monitor: every rising response is one completed request.
    initial begin
        bit prev = 1'b1;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && response && !prev) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_response: out=0x%08h with empty scoreboard", out);
                end else begin
                    e = sb.pop_front();
                    check("out", out, e.val);
                    check("done_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            prev = response;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, a;
        logic        w;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        check("reset_response", {31'd0, response}, 32'd1);
        check("reset_out", out, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        check("idle_response", {31'd0, response}, 32'd1);

        issue("write5", 32'hDEADBEEF, 32'd5, 1'b1, 0);
        check("write_out", out, cur_out);
        issue("read5", 32'd0, 32'd5, 1'b0, 0);
        issue("alias_write", 32'h12345678, 32'h0000_1005, 1'b1, 0);
        issue("alias_read", 32'd0, 32'd5, 1'b0, 0);
        issue("abort_write", 32'hAAAA0000, 32'd7, 1'b1, 2);
        issue("read7", 32'd0, 32'd7, 1'b0, 0);

        // Unchanged inputs after completion must not start anything.
        data = 32'd0; addr = 32'd7; wr = 1'b0;
        repeat (LATENCY + 2) @(negedge clk);
        #1;
        check("repeat_response", {31'd0, response}, 32'd1);

        // Async reset while cnt==2, between clock edges.
        drive(32'd0, 32'd5, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_response", {31'd0, response}, 32'd0);
        check("rst_mid_out", out, 32'd0);
        cur_out = 32'd0;
        #1 rst = 1'b0;
        push_expected(32'd0, 32'd5, 1'b0);
        wait_done("post_reset_read");

        for (int n = 0; n < 48; n++) begin
            do begin
                w = 1'($urandom_range(0, 1));
                a = ($urandom & ~LOW_MASK) | 32'($urandom_range(0, 15));
                d = $urandom;
            end while (d == data && a == addr && w == wr);
            issue("rand", d, a, w, ($urandom_range(0, 3) == 0) ? $urandom_range(1, LATENCY) : 0);
        end
        d = 32'd0;
        a = 32'($urandom_range(0, 15));
        if (a == addr) a = a ^ 32'd1;
        issue("final_read", d, a, 1'b0, 0);

        repeat (LATENCY + 2) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/latency_ram.md
Name: latency_ram

Overview:
- Word-addressed 32-bit backing memory with fixed multi-cycle access latency and a level "response" done flag.
- Sits behind the cache as its main-memory model. The cache drives data/addr/wr and waits for response=1 before using out.
- A request is started implicitly whenever any request input differs from the last accepted request; there is no separate valid strobe.

Parameters:
- ADDR_W, 12, number of low address bits used as the word index; depth = 2**ADDR_W words.
- LATENCY, 4, clock edges from request acceptance to completion; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- data  input  32  write data.
- addr  input  32  word address; only addr[ADDR_W-1:0] is used, upper bits are ignored (aliasing).
- wr  input  1  1 = write, 0 = read.
- response  output  1  1 = last accepted request complete and inputs unchanged since.
- out  output  32  read data.

Behaviour:
- State registers:
  - latched data_q/addr_q/wr_q.
  - down-counter cnt (8 bits).
  - done flag.
  - out register.
  - memory array of 2**ADDR_W x 32.
- Reset (async, active-high):
  - data_q=0, addr_q=0, wr_q=0, cnt=0, done=1, out=0.
  - Memory contents are not cleared by reset. Simulation initial contents are all-zero.
- mismatch (combinational) = (data!=data_q) | (addr!=addr_q) | (wr!=wr_q).
- response = done & ~mismatch (combinational).
  - response drops in the same cycle the inputs change, so a requester never sees a stale 1.
- Each posedge clk, in priority order:
  - 1. mismatch:
    - latch data/addr/wr into *_q, done=0, cnt=LATENCY-1.
    - Any in-flight request is aborted; an aborted write is never performed.
  - 2. else if ~done and cnt!=0: cnt=cnt-1.
  - 3. else if ~done and cnt==0, perform the access using the latched values, then set done=1:
    - write: mem[addr_q[ADDR_W-1:0]]=data_q.
    - read: out=mem[addr_q[ADDR_W-1:0]].
  - 4. else: idle, hold all state.
- Latency: inputs changed before edge E0 are accepted at E0; the access and done=1 occur at edge E0+LATENCY.
  - response is high from just after E0+LATENCY.
  - LATENCY=1 completes on the next edge.
- out changes only on read completion (or reset). A write leaves out unchanged (see Optional Feature).
- Reading an address that is still being written: not possible, since only one request is in flight; a read after a completed write returns the new data.
- Repeating an identical request (same data/addr/wr) after completion starts nothing; response stays 1.
  - To re-read, the requester must change at least one input.
- No X-propagation from unused addr upper bits.

Optional Feature:
- Macro RAM_WR_READBACK_EN.
- Defined: on write completion, out is also loaded with data_q (same edge as the array write).
- Undefined: out holds its previous value across writes.

Test Plan:
- Reset with inputs all-zero: rst=1 then 0 -> response=1, out=0, no counting.
- Write: data=0xDEADBEEF, addr=5, wr=1 applied:
  - response=0 in the same cycle.
  - After 4 edges response=1.
  - out unchanged (0xDEADBEEF if RAM_WR_READBACK_EN).
- Read back: addr=5, wr=0, data=0 -> response low 4 edges, then out=0xDEADBEEF, response=1.
- Aliasing: write 0x12345678 to addr=0x1005 and complete, then read addr=5 -> out=0x12345678.
- Abort: start write 0xAAAA0000 to addr=7, change to a read of addr=7 after 2 edges -> the write is never performed.
  - Read completes 4 edges after the change with the prior contents of addr 7 (0).
- Async reset mid-request: assert rst during cnt=2, without a clock edge ->
  - done=1, out=0 and latched inputs cleared immediately.
  - response=1 if the inputs are zero, else 0 followed by a fresh request on the next edge.
